// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DEFAULT_DATA_BITS    = 8;
  // start + 8 data + stop
  localparam int FRAME_BITS_8N1       = 10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BRK   = 3'd4;

endpackage

// File: rtl/uart_rx_sync2.sv
// rtl/uart_rx_sync2.sv - two-flop synchroniser for an async pin, resets to 1 (line idle)
module sync2 (
  input  logic C,
  input  logic R,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      s1 <= 1'b1;
      q  <= 1'b1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with valid/ready byte output
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 C,
  input  logic                 R,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun
);

  if ((CLKS_PER_BIT < 4) || ((CLKS_PER_BIT % 2) != 0)) begin : g_bad_clks
    $error("uart_rx: CLKS_PER_BIT must be even and >= 4");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_bits
    $error("uart_rx: DATA_BITS must be 5..9");
  end

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 rxd_s;
  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 done;

  sync2 u_sync (
    .C(C),
    .R(R),
    .d(rxd),
    .q(rxd_s)
  );

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      done      <= 1'b0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!rxd_s) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end
        ST_START: begin
          // mid-start-bit recheck rejects short glitches
          if (cnt == HALF_LAST) begin
            if (!rxd_s) begin
              state   <= ST_DATA;
              cnt     <= '0;
              bit_idx <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == BIT_LAST) state <= ST_STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == FULL_LAST) begin
            cnt <= '0;
            if (rxd_s) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BRK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BRK: begin
          // a held-low line must go high before the next start is armed
          if (rxd_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (done) begin
        if (!valid || ready) begin
          data  <= shreg;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx, H=16, 8 data bits
module tb_uart_rx;

  logic       C = 1'b0;
  logic       R = 1'b0;
  logic       rxd = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  int n_chk = 0;
  int n_pass = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int acc_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut (
    .C(C),
    .R(R),
    .rxd(rxd),
    .data(data),
    .valid(valid),
    .ready(ready),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 C = ~C;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always begin
    @(negedge C);
    #1;
    if (R && prev_valid && !prev_ready) chk("hold", {valid, data}, {1'b1, prev_data});
    if (valid && ready) begin
      acc_cnt++;
      if (exp_q.size() == 0) chk("unexpected_accept", {1'b1, data}, 9'h0);
      else chk("data", data, exp_q.pop_front());
    end
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    prev_valid = valid;
    prev_ready = ready;
    prev_data  = data;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge C);
      rxd = 1'b1;
    end
  endtask

  // ready_at pulses ready for one cycle at that index; rst_at asserts R mid-frame
  task automatic send_frame(input logic [7:0] b, input logic stop, input int ready_at,
                            input logic chk_lat, input int rst_at);
    for (int i = 0; i < 160; i++) begin
      int k;
      @(negedge C);
      k = i / 16;
      if (k == 0)      rxd = 1'b0;
      else if (k <= 8) rxd = b[k-1];
      else             rxd = stop;
      if (i == ready_at)          ready = 1'b1;
      else if (i == ready_at + 1) ready = 1'b0;
      if (chk_lat && i == 155) chk("lat_before", valid, 1'b0);
      if (chk_lat && i == 156) begin
        chk("lat_valid", valid, 1'b1);
        chk("lat_data", data, b);
      end
      if (chk_lat && i == 157) chk("lat_pulse", valid, 1'b0);
      if (i == rst_at) begin
        #2 R = 1'b0;
        #1;
        chk("arst_data", data, 8'h00);
        chk("arst_valid", valid, 1'b0);
        chk("arst_fe", frame_err, 1'b0);
        chk("arst_ov", overrun, 1'b0);
        break;
      end
    end
  endtask

  initial begin
    int fe0, ov0, acc0;
    R = 1'b0;
    repeat (3) @(negedge C);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_fe", frame_err, 1'b0);
    chk("rst_ov", overrun, 1'b0);
    R = 1'b1;
    idle(20);

    // nominal
    ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -5, 1'b1, -5);
    idle(20);
    chk("nom_fe", fe_cnt, 0);
    chk("nom_ov", ov_cnt, 0);
    chk("nom_acc", acc_cnt, 1);

    // glitch
    acc0 = acc_cnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge C);
      rxd = 1'b0;
    end
    idle(200);
    chk("glitch_acc", acc_cnt, acc0);
    chk("glitch_valid", valid, 1'b0);
    chk("glitch_fe", fe_cnt, 0);

    // framing error then break, then recovery
    acc0 = acc_cnt;
    send_frame(8'h3C, 1'b0, -5, 1'b0, -5);
    for (int i = 0; i < 40; i++) begin
      @(negedge C);
      rxd = 1'b0;
    end
    idle(20);
    chk("frm_fe", fe_cnt, 1);
    chk("frm_acc", acc_cnt, acc0);
    chk("frm_valid", valid, 1'b0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -5, 1'b0, -5);
    idle(20);
    chk("frm_recover_acc", acc_cnt, acc0 + 1);

    // overrun
    ready = 1'b0;
    ov0 = ov_cnt;
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, -5, 1'b0, -5);
    send_frame(8'h02, 1'b1, -5, 1'b0, -5);
    idle(10);
    chk("ovr_pulse", ov_cnt, ov0 + 1);
    chk("ovr_valid", valid, 1'b1);
    chk("ovr_data", data, 8'h01);
    @(negedge C);
    ready = 1'b1;
    @(negedge C);
    ready = 1'b0;
    @(negedge C);
    chk("ovr_drop_valid", valid, 1'b0);
    chk("ovr_keep_data", data, 8'h01);
    idle(10);

    // accept and load in the same cycle
    ov0 = ov_cnt;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, -5, 1'b0, -5);
    exp_q.push_back(8'hAA);
    send_frame(8'hAA, 1'b1, 155, 1'b0, -5);
    idle(10);
    chk("al_valid", valid, 1'b1);
    chk("al_data", data, 8'hAA);
    chk("al_ov", ov_cnt, ov0);
    @(negedge C);
    ready = 1'b1;
    @(negedge C);
    ready = 1'b0;
    idle(10);

    // reset during data bit 3
    ready = 1'b1;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'hFF, 1'b1, -5, 1'b0, 16 * 4 + 8);
    rxd = 1'b1;
    repeat (3) @(negedge C);
    R = 1'b1;
    idle(20);
    exp_q.push_back(8'h80);
    send_frame(8'h80, 1'b1, -5, 1'b0, -5);
    idle(20);
    chk("rst_mid_fe", fe_cnt, fe0);
    chk("rst_mid_ov", ov_cnt, ov0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
